// File: rtl/stream_demux_n_if.sv
// Stream bundle for the 1:N demultiplexer: one producer-side channel,
// N consumer-side channels and the drop counter status output.
interface stream_demux_n_if #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int CNT_W  = 8
);
  localparam int SEL_W = $clog2(N_OUT);

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_bcast;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_ready;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic [CNT_W-1:0]        drop_cnt;

  // Environment view: drives the producer and the consumers' ready lines.
  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data, drop_cnt
  );

  // Demux view.
  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data, drop_cnt
  );
endinterface

// File: rtl/stream_demux_n.sv
// Registered 1:N stream demultiplexer. Each input word goes to the channel
// named by in_sel, or to every channel in broadcast mode. Each channel has a
// single register stage; words with an out-of-range select are accepted,
// discarded and counted in a saturating counter.
module stream_demux_n #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int CNT_W  = 8
) (
  input logic             clk,
  input logic             rst,
  stream_demux_n_if.slave bus
);
  localparam int SEL_W = $clog2(N_OUT);
  // Number of codes the select field can carry; codes >= N_OUT are illegal.
  localparam int SEL_N = 1 << SEL_W;

  logic [N_OUT-1:0]        out_valid_q, out_valid_d;
  logic [N_OUT*DATA_W-1:0] out_data_q,  out_data_d;
  logic [CNT_W-1:0]        drop_cnt_q,  drop_cnt_d;

  logic [N_OUT-1:0]        free_s;
  logic [SEL_N-1:0]        free_ext_s;
  logic [SEL_N-1:0]        legal_ext_s;
  logic                    in_ready_s;
  logic                    accept_s;

  // Per-channel free flags, widened over the full select code space so an
  // illegal code reads as "free" (always accepted) and "not legal".
  always_comb begin
    free_s      = ~out_valid_q | bus.out_ready;
    free_ext_s  = {SEL_N{1'b1}};
    legal_ext_s = {SEL_N{1'b0}};
    for (int i = 0; i < N_OUT; i++) begin
      free_ext_s[i]  = free_s[i];
      legal_ext_s[i] = 1'b1;
    end
  end

  // Input handshake: broadcast needs every channel free at once, unicast only its target.
  always_comb begin
    if (bus.in_bcast) begin
      in_ready_s = &free_s;
    end else begin
      in_ready_s = free_ext_s[bus.in_sel];
    end
    accept_s = bus.in_valid & in_ready_s;
  end

  // Next-state: drain consumed channels, then let an accepted word load (load beats drain).
  always_comb begin
    out_valid_d = out_valid_q & ~bus.out_ready;
    out_data_d  = out_data_q;
    drop_cnt_d  = drop_cnt_q;
    if (accept_s) begin
      if (bus.in_bcast) begin
        out_valid_d = {N_OUT{1'b1}};
        out_data_d  = {N_OUT{bus.in_data}};
      end else if (legal_ext_s[bus.in_sel]) begin
        for (int i = 0; i < N_OUT; i++) begin
          if (bus.in_sel == SEL_W'(i)) begin
            out_valid_d[i]                  = 1'b1;
            out_data_d[i*DATA_W +: DATA_W]  = bus.in_data;
          end else begin
            // other channels keep their drain-only value
          end
        end
      end else begin
        // illegal select: word is swallowed, counter saturates at all-ones
        if (drop_cnt_q != {CNT_W{1'b1}}) begin
          drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end else begin
          drop_cnt_d = drop_cnt_q;
        end
      end
    end else begin
      // no accept: only drains change state
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= {N_OUT{1'b0}};
      out_data_q  <= {(N_OUT*DATA_W){1'b0}};
      drop_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux_n.sv
// Self-checking bench for stream_demux_n: a table of directed vectors on a
// 4-channel instance plus a hand-written illegal-select sequence on a
// 3-channel instance.
module tb_stream_demux_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4;
  logic rst3;

  stream_demux_n_if #(.DATA_W(8), .N_OUT(4), .CNT_W(8)) if4 ();
  stream_demux_n_if #(.DATA_W(8), .N_OUT(3), .CNT_W(8)) if3 ();

  stream_demux_n #(.DATA_W(8), .N_OUT(4), .CNT_W(8)) u_dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (if4)
  );

  stream_demux_n #(.DATA_W(8), .N_OUT(3), .CNT_W(8)) u_dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (if3)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One vector: inputs applied for a cycle; expectations describe in_ready for
  // those inputs and the registered state produced by the preceding vectors.
  typedef struct {
    logic        rst;
    logic        vld;
    logic        bc;
    logic [1:0]  sel;
    logic [7:0]  dat;
    logic [3:0]  ordy;
    logic        chk_rdy;
    logic        exp_rdy;
    logic        chk_st;
    logic [3:0]  exp_ov;
    logic [31:0] exp_od;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic r, input logic v, input logic b, input logic [1:0] s,
                     input logic [7:0] d, input logic [3:0] o, input logic cr, input logic er,
                     input logic cs, input logic [3:0] eov, input logic [31:0] eod);
    vec_t t;
    t.rst = r; t.vld = v; t.bc = b; t.sel = s; t.dat = d; t.ordy = o;
    t.chk_rdy = cr; t.exp_rdy = er; t.chk_st = cs; t.exp_ov = eov; t.exp_od = eod;
    tbl.push_back(t);
  endtask

  initial begin
    rst4 = 1'b1;
    rst3 = 1'b1;
    if4.in_valid = 1'b0; if4.in_bcast = 1'b0; if4.in_sel = 2'd0; if4.in_data = 8'h00;
    if4.out_ready = 4'h0;
    if3.in_valid = 1'b0; if3.in_bcast = 1'b0; if3.in_sel = 2'd0; if3.in_data = 8'h00;
    if3.out_ready = 3'h0;

    //   rst  vld  bc   sel    dat     ordy     crdy erdy cst  ov        od
    // reset for two clocks with in_valid high
    row(1'b1,1'b1,1'b0,2'd0,8'h11,4'hF,    1'b0,1'b0,1'b0,4'b0000,32'h00000000);
    row(1'b1,1'b1,1'b0,2'd0,8'h22,4'hF,    1'b0,1'b0,1'b1,4'b0000,32'h00000000);
    row(1'b0,1'b0,1'b0,2'd0,8'h00,4'hF,    1'b1,1'b1,1'b1,4'b0000,32'h00000000);
    // unicast sweep, all consumers ready
    row(1'b0,1'b1,1'b0,2'd0,8'hA0,4'hF,    1'b1,1'b1,1'b1,4'b0000,32'h00000000);
    row(1'b0,1'b1,1'b0,2'd1,8'hA1,4'hF,    1'b1,1'b1,1'b1,4'b0001,32'h000000A0);
    row(1'b0,1'b1,1'b0,2'd2,8'hA2,4'hF,    1'b1,1'b1,1'b1,4'b0010,32'h0000A1A0);
    row(1'b0,1'b1,1'b0,2'd3,8'hA3,4'hF,    1'b1,1'b1,1'b1,4'b0100,32'h00A2A1A0);
    row(1'b0,1'b0,1'b0,2'd0,8'h00,4'hF,    1'b1,1'b1,1'b1,4'b1000,32'hA3A2A1A0);
    row(1'b0,1'b0,1'b0,2'd0,8'h00,4'hF,    1'b1,1'b1,1'b1,4'b0000,32'hA3A2A1A0);
    // back-pressure on channel 2
    row(1'b0,1'b1,1'b0,2'd2,8'h55,4'b1011, 1'b1,1'b1,1'b1,4'b0000,32'hA3A2A1A0);
    row(1'b0,1'b1,1'b0,2'd2,8'h66,4'b1011, 1'b1,1'b0,1'b1,4'b0100,32'hA355A1A0);
    row(1'b0,1'b1,1'b0,2'd2,8'h66,4'b1011, 1'b1,1'b0,1'b1,4'b0100,32'hA355A1A0);
    row(1'b0,1'b1,1'b0,2'd2,8'h66,4'hF,    1'b1,1'b1,1'b1,4'b0100,32'hA355A1A0);
    row(1'b0,1'b0,1'b0,2'd2,8'h00,4'hF,    1'b1,1'b1,1'b1,4'b0100,32'hA366A1A0);
    row(1'b0,1'b0,1'b0,2'd2,8'h00,4'hF,    1'b1,1'b1,1'b1,4'b0000,32'hA366A1A0);
    // broadcast blocked by stalled channel 2, unicast to ch3 still flows
    row(1'b0,1'b1,1'b0,2'd2,8'h99,4'b1011, 1'b1,1'b1,1'b1,4'b0000,32'hA366A1A0);
    row(1'b0,1'b1,1'b1,2'd0,8'h3C,4'b1011, 1'b1,1'b0,1'b1,4'b0100,32'hA399A1A0);
    row(1'b0,1'b1,1'b0,2'd3,8'h44,4'b1011, 1'b1,1'b1,1'b1,4'b0100,32'hA399A1A0);
    row(1'b0,1'b1,1'b1,2'd0,8'h3C,4'b1011, 1'b1,1'b0,1'b1,4'b1100,32'h4499A1A0);
    row(1'b0,1'b1,1'b1,2'd0,8'h3C,4'hF,    1'b1,1'b1,1'b1,4'b0100,32'h4499A1A0);
    row(1'b0,1'b0,1'b0,2'd0,8'h00,4'hF,    1'b1,1'b1,1'b1,4'b1111,32'h3C3C3C3C);
    row(1'b0,1'b0,1'b0,2'd0,8'h00,4'hF,    1'b1,1'b1,1'b1,4'b0000,32'h3C3C3C3C);
    // mid-operation reset while ch1 holds a stalled word
    row(1'b0,1'b1,1'b0,2'd1,8'h77,4'h0,    1'b1,1'b1,1'b1,4'b0000,32'h3C3C3C3C);
    row(1'b0,1'b0,1'b0,2'd1,8'h00,4'h0,    1'b1,1'b0,1'b1,4'b0010,32'h3C3C773C);
    row(1'b1,1'b0,1'b0,2'd1,8'h00,4'h0,    1'b0,1'b0,1'b1,4'b0010,32'h3C3C773C);
    row(1'b0,1'b0,1'b0,2'd1,8'h00,4'h0,    1'b1,1'b1,1'b1,4'b0000,32'h00000000);

    foreach (tbl[k]) begin
      @(negedge clk);
      rst4          = tbl[k].rst;
      if4.in_valid  = tbl[k].vld;
      if4.in_bcast  = tbl[k].bc;
      if4.in_sel    = tbl[k].sel;
      if4.in_data   = tbl[k].dat;
      if4.out_ready = tbl[k].ordy;
      #1;
      if (tbl[k].chk_rdy) begin
        check($sformatf("row%0d in_ready", k), {63'd0, if4.in_ready}, {63'd0, tbl[k].exp_rdy});
      end
      if (tbl[k].chk_st) begin
        check($sformatf("row%0d out_valid", k), {60'd0, if4.out_valid}, {60'd0, tbl[k].exp_ov});
        check($sformatf("row%0d out_data", k), {32'd0, if4.out_data}, {32'd0, tbl[k].exp_od});
        check($sformatf("row%0d drop_cnt", k), {56'd0, if4.drop_cnt}, 64'd0);
      end
    end
    @(negedge clk);
    if4.in_valid = 1'b0;

    // Illegal select on the 3-channel instance: code 3 is out of range.
    rst3 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst3 = 1'b0;
    if3.out_ready = 3'b111;
    #1;
    check("n3 reset out_valid", {61'd0, if3.out_valid}, 64'd0);
    check("n3 reset drop_cnt", {56'd0, if3.drop_cnt}, 64'd0);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if3.in_valid = 1'b1;
      if3.in_bcast = 1'b0;
      if3.in_sel   = 2'd3;
      if3.in_data  = 8'(k);
      #1;
      check($sformatf("n3 illegal in_ready %0d", k), {63'd0, if3.in_ready}, 64'd1);
      check($sformatf("n3 illegal out_valid %0d", k), {61'd0, if3.out_valid}, 64'd0);
      check($sformatf("n3 drop_cnt %0d", k), {56'd0, if3.drop_cnt}, (k > 255) ? 64'd255 : 64'(k));
    end
    @(negedge clk);
    if3.in_valid = 1'b0;
    #1;
    check("n3 drop_cnt saturated", {56'd0, if3.drop_cnt}, 64'hFF);
    check("n3 idle out_valid", {61'd0, if3.out_valid}, 64'd0);
    // A legal word still routes normally after saturation.
    @(negedge clk);
    if3.in_valid = 1'b1;
    if3.in_sel   = 2'd2;
    if3.in_data  = 8'h5A;
    #1;
    check("n3 legal in_ready", {63'd0, if3.in_ready}, 64'd1);
    @(negedge clk);
    if3.in_valid = 1'b0;
    #1;
    check("n3 legal out_valid", {61'd0, if3.out_valid}, 64'd4);
    check("n3 legal out_data", {56'd0, if3.out_data[23:16]}, 64'h5A);
    check("n3 drop_cnt held", {56'd0, if3.drop_cnt}, 64'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
